vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator; successor to the fixed 640x480 controller. Derives a pixel-rate enable from the system clock, runs programmable horizontal/vertical counters, and emits sync, blank, coordinates and frame/line strobes. A configurable RGB latency pipeline keeps sync and blank aligned with pixel colour from the downstream renderer (sprite/paddle/ball logic). It sits between the CPU-side framebuffer/renderer and the DAC pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths, in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths, in lines
- H_POL / V_POL, 0 / 0, active sync level (0 = active-low)
- CLK_DIV, 2, system clocks per pixel (≥1)
- COLOR_W, 4, bits per colour channel
- RGB_LAT, 1, pixel slots from x/y presentation to rgb_in capture plus one (≥1)
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rgb_in  in  3*COLOR_W  {r,g,b} for the pixel presented RGB_LAT-1 slots earlier
- pix_en  out  1  one-clk pixel strobe
- x / y  out  H_W / V_W  current counter position (H_W = $clog2(H_TOTAL), V_W = $clog2(V_TOTAL))
- active  out  1  x<H_ACTIVE && y<V_ACTIVE (stage 0, unaligned)
- line_start / frame_start  out  1  one-clk strobes
- hsync / vsync / blank_n  out  1  aligned with rgb_out
- rgb_out  out  3*COLOR_W  pipelined colour; zero while blanked

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line order: active, front porch, sync, back porch.
- Divider counts 0..CLK_DIV-1. pix_en is high while the divider equals CLK_DIV-1. With CLK_DIV=1, pix_en is constant 1 out of reset.
- On pix_en: x increments. When x==H_TOTAL-1, x←0 and y increments. When y==V_TOTAL-1 at the same wrap, y←0.
- Sync assertion conditions (then XOR'd for polarity):
  - hsync active when H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC.
  - vsync active over the equivalent line range.
- line_start = pix_en && x==0. frame_start = pix_en && x==0 && y==0.
- Alignment pipeline: {hsync, vsync, active} is shifted through RGB_LAT registers, each advancing on pix_en. rgb_in is registered on pix_en into rgb_out and forced to 0 when the aligned blank_n is 0.
- Reset values:
  - all counters and x/y: 0.
  - pix_en, line_start, frame_start, blank_n, active pipeline: 0.
  - hsync = ~H_POL; vsync = ~V_POL.
  - rgb_out: 0.
- Reset mid-frame: all state clears immediately. Counting restarts at (0,0) after rst falls; the first pix_en arrives CLK_DIV clocks later.

## Timing
- Counter update latency: x/y change on the clk edge that samples pix_en=1.
- Pixel slot n shows x/y at stage 0. The renderer must drive rgb_in for that pixel during slot n+RGB_LAT-1. rgb_out, hsync, vsync and blank_n for pixel n are valid throughout slot n+RGB_LAT.
- All outputs are registered except pix_en, line_start, frame_start and active, which decode registered state only.
- rgb_in is sampled only on pix_en cycles. Other cycles are don't-care.

## Configuration
- VGA_TIMING_TEST_PATTERN_EN defined: adds input pattern_sel (1 bit).
  - When pattern_sel=1, the rgb_in capture is replaced by eight vertical bars. Bar index b = x*8/H_ACTIVE, computed from the x delayed RGB_LAT-1 slots.
  - Channel values: r=b[2], g=b[1], b=b[0], each replicated to COLOR_W bits.
  - The bar colour still passes through the same capture register, so the pattern has the same alignment as rgb_in.
- Macro undefined: no pattern_sel port, no bar logic; rgb_in always used.

## Structure
- Package vga_timing_pkg holds:
  - localparam defaults for 640x480@60 (the H_*/V_* values above);
  - a 800x600 set;
  - a function computing TOTAL and counter width from a timing set.
- Sub-module vga_axis_counter (parameters ACTIVE/FP/SYNC/BP/POL):
  - one programmable wrapping counter with enable;
  - outputs count, wrap, sync and active;
  - instantiated twice. The vertical instance is enabled by pix_en && horizontal wrap.

## Test plan
- Small timing (H 8/2/2/2, V 4/1/1/1, CLK_DIV=2, RGB_LAT=1): hsync low for x=10..11; line period 28 clks; frame_start every 196 clks.
- Reset: assert rst mid-line at x=5 → x,y,rgb_out go to 0 and hsync=1 without a clock edge. After release, first pix_en at clk 2.
- Alignment (RGB_LAT=3): drive rgb_in = slot-indexed value with renderer latency 2 → rgb_out for x=0 appears in the same slot as blank_n rising; rgb_out=0 during porches.
- Wrap: at x=13, y=6 on pix_en → x=0, y=0, frame_start=1 for exactly one clk.
- Polarity: H_POL=1, V_POL=1 → hsync/vsync high only during the sync window; reset value 0.
- Test pattern (macro defined, pattern_sel=1, H_ACTIVE=640): x=0 → rgb_out 000/000/000; x=400 → bar 5 → r=F, g=0, b=F.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared types and constants for the VGA raster timing generator.
//   timing_t        : one axis timing set (active, front porch, sync, back porch)
//   align_t         : per-pixel sync/blank bundle carried by the alignment pipe
//   VGA_640X480_*   : 640x480@60 timing sets (the generator defaults)
//   VGA_800X600_*   : 800x600@60 timing sets
//   timing_total()  : pixels/lines per period of a timing set
//   timing_width()  : counter width needed to span a timing set
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } timing_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } align_t;

    localparam timing_t VGA_640X480_H = '{active: 640, fp: 16, sync: 96,  bp: 48};
    localparam timing_t VGA_640X480_V = '{active: 480, fp: 10, sync: 2,   bp: 33};
    localparam timing_t VGA_800X600_H = '{active: 800, fp: 40, sync: 128, bp: 88};
    localparam timing_t VGA_800X600_V = '{active: 600, fp: 1,  sync: 4,   bp: 23};

    function automatic int timing_total(timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    function automatic int timing_width(timing_t t);
        int total;
        total = timing_total(t);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a wrapping position counter with enable, plus decodes of
// the sync window and the visible region. Used once per axis.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   en       : advance the counter by one on this clock
//   count    : current position, 0 .. TOTAL-1
//   wrap     : count is at TOTAL-1 (next enabled step returns to 0)
//   sync     : sync level for the current position (POL = active level)
//   active   : count lies in the visible region
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    localparam timing_t SET   = '{active: ACTIVE, fp: FP, sync: SYNC, bp: BP},
    localparam int      TOTAL = timing_total(SET),
    localparam int      W     = timing_width(SET)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         sync,
    output logic         active
);

    localparam logic [31:0] SYNC_LO = 32'(ACTIVE + FP);
    localparam logic [31:0] SYNC_HI = 32'(ACTIVE + FP + SYNC);
    localparam logic [31:0] LAST    = 32'(TOTAL - 1);
    localparam logic [31:0] VIS_END = 32'(ACTIVE);

    // Compare at 32 bits so window edges equal to TOTAL never alias to 0.
    logic [31:0] count_ext;
    logic        in_sync;

    assign count_ext = 32'(count);
    assign wrap      = (count_ext == LAST);
    assign in_sync   = (count_ext >= SYNC_LO) && (count_ext < SYNC_HI);
    assign sync      = in_sync ? POL : !POL;
    assign active    = (count_ext < VIS_END);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator. Divides clk down to a pixel
// strobe, walks x/y over the programmed raster and delays sync/blank by
// RGB_LAT pixel slots so they line up with the renderer's colour.
// Optional build macro: VGA_TIMING_TEST_PATTERN_EN adds pattern_sel, which
// replaces rgb_in with eight vertical colour bars.
// Ports:
//   clk, rst        : system clock, asynchronous active-high reset
//   pattern_sel     : (macro only) 1 = colour bars instead of rgb_in
//   rgb_in          : {r,g,b} for the pixel shown RGB_LAT-1 slots earlier
//   pix_en          : one-clk pixel strobe
//   x, y            : current raster position (unaligned)
//   active          : x/y inside the visible area (unaligned)
//   line_start      : pix_en at x==0
//   frame_start     : pix_en at x==0, y==0
//   hsync, vsync    : sync outputs, aligned with rgb_out
//   blank_n         : visible-area flag, aligned with rgb_out
//   rgb_out         : registered colour, zero while blanked
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_640X480_H.active,
    parameter int H_FP     = VGA_640X480_H.fp,
    parameter int H_SYNC   = VGA_640X480_H.sync,
    parameter int H_BP     = VGA_640X480_H.bp,
    parameter int V_ACTIVE = VGA_640X480_V.active,
    parameter int V_FP     = VGA_640X480_V.fp,
    parameter int V_SYNC   = VGA_640X480_V.sync,
    parameter int V_BP     = VGA_640X480_V.bp,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int COLOR_W  = 4,
    parameter int RGB_LAT  = 1,
    localparam timing_t H_SET = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP},
    localparam timing_t V_SET = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP},
    localparam int H_W   = timing_width(H_SET),
    localparam int V_W   = timing_width(V_SET),
    localparam int RGB_W = 3 * COLOR_W
) (
    input  logic             clk,
    input  logic             rst,
`ifdef VGA_TIMING_TEST_PATTERN_EN
    input  logic             pattern_sel,
`endif
    input  logic [RGB_W-1:0] rgb_in,
    output logic             pix_en,
    output logic [H_W-1:0]   x,
    output logic [V_W-1:0]   y,
    output logic             active,
    output logic             line_start,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic             blank_n,
    output logic [RGB_W-1:0] rgb_out
);

    localparam int     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam align_t IDLE_SIG = '{hsync: !H_POL, vsync: !V_POL, active: 1'b0};

    // ---------------- pixel-rate divider ----------------
    logic [DIV_W-1:0] div;

    // With CLK_DIV=1 the divider never leaves 0, so pix_en is permanently 1.
    assign pix_en = (div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (pix_en) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // ---------------- raster counters ----------------
    logic h_wrap, h_sync, h_active;
    logic v_wrap, v_sync, v_active;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL)
    ) u_h_axis (
        .clk    (clk),
        .rst    (rst),
        .en     (pix_en),
        .count  (x),
        .wrap   (h_wrap),
        .sync   (h_sync),
        .active (h_active)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL)
    ) u_v_axis (
        .clk    (clk),
        .rst    (rst),
        .en     (pix_en && h_wrap),
        .count  (y),
        .wrap   (v_wrap),
        .sync   (v_sync),
        .active (v_active)
    );

    assign active      = h_active && v_active;
    assign line_start  = pix_en && (x == '0);
    assign frame_start = line_start && (y == '0);

    // ---------------- sync/blank alignment pipeline ----------------
    align_t stage0;
    align_t stage [RGB_LAT];
    align_t pre_last;   // value entering the final stage on this pix_en

    assign stage0 = '{hsync: h_sync, vsync: v_sync, active: active};

    // NOTE: the pipeline stages are reset too: they drive hsync/vsync/blank_n
    // directly, so they must show an idle raster until real pixels reach them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RGB_LAT; i++) begin
                stage[i] <= IDLE_SIG;
            end
        end else if (pix_en) begin
            stage[0] <= stage0;
            for (int i = 1; i < RGB_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    generate
        if (RGB_LAT == 1) begin : g_pre_direct
            assign pre_last = stage0;
        end else begin : g_pre_stage
            assign pre_last = stage[RGB_LAT-2];
        end
    endgenerate

    assign hsync   = stage[RGB_LAT-1].hsync;
    assign vsync   = stage[RGB_LAT-1].vsync;
    assign blank_n = stage[RGB_LAT-1].active;

    // ---------------- colour source ----------------
    logic [RGB_W-1:0] color_src;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    // Bars follow x delayed RGB_LAT-1 slots, i.e. the pixel a renderer
    // would be colouring right now.
    logic [H_W-1:0]   x_del;
    logic [2:0]       bar;
    logic [RGB_W-1:0] bar_rgb;

    generate
        if (RGB_LAT == 1) begin : g_x_direct
            assign x_del = x;
        end else begin : g_x_hist
            logic [H_W-1:0] x_hist [RGB_LAT-1];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < RGB_LAT - 1; i++) begin
                        x_hist[i] <= '0;
                    end
                end else if (pix_en) begin
                    x_hist[0] <= x;
                    for (int i = 1; i < RGB_LAT - 1; i++) begin
                        x_hist[i] <= x_hist[i-1];
                    end
                end
            end
            assign x_del = x_hist[RGB_LAT-2];
        end
    endgenerate

    // Bar index beyond 7 only occurs in blanking, where the colour is masked.
    assign bar       = 3'((32'(x_del) * 32'd8) / 32'(H_ACTIVE));
    assign bar_rgb   = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
    assign color_src = pattern_sel ? bar_rgb : rgb_in;
`else
    assign color_src = rgb_in;
`endif

    // Masking uses the blank flag that becomes visible together with this
    // colour, so rgb_out is zero exactly while blank_n is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_out <= '0;
        end else if (pix_en) begin
            rgb_out <= pre_last.active ? color_src : '0;
        end
    end

endmodule
